// File: rtl/debug_ram_reader_if.sv
// Output stream of the debug RAM readout engine: valid/ready beats with a last marker.
interface debug_ram_reader_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/debug_ram_reader.sv
// Streams a run of consecutive words (wrapping modulo DEPTH) out of a single-port RAM
// through a 2-entry output FIFO, with one read in flight at most beyond the FIFO space.
module debug_ram_reader #(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 1024,
    localparam int AWIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [AWIDTH-1:0]        start_addr,
    input  logic [AWIDTH:0]          length,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [AWIDTH-1:0]        ram_addr,
    output logic                     ram_we,
    input  logic [WIDTH-1:0]         ram_dat_out,
    debug_ram_reader_if.master       m_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0]   REM_ONE   = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0]   LEN_ZERO  = {(AWIDTH+1){1'b0}};
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH-1:0] ADDR_ONE  = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] ADDR_ZERO = {AWIDTH{1'b0}};

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [AWIDTH:0]   remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              head_vld_q, head_vld_d;
    logic              head_last_q, head_last_d;
    logic [WIDTH-1:0]  head_data_q, head_data_d;
    logic              tail_vld_q, tail_vld_d;
    logic              tail_last_q, tail_last_d;
    logic [WIDTH-1:0]  tail_data_q, tail_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              pop_s;
    logic              push_s;
    logic              start_ok_s;
    logic              abort_ok_s;
    logic              issue_s;
    logic              last_issue_s;
    logic [1:0]        occ_s;
    logic [1:0]        limit_s;
    logic [AWIDTH:0]   len_clamped_s;
    logic [AWIDTH-1:0] addr_next_s;

    assign pop_s         = head_vld_q & m_if.m_ready;
    assign push_s        = inflight_q;
    assign start_ok_s    = (state_q == IDLE) && start && (length != LEN_ZERO);
    assign abort_ok_s    = abort && (state_q != IDLE);
    assign len_clamped_s = (length > DEPTH_W) ? DEPTH_W : length;
    assign addr_next_s   = (addr_q == LAST_ADDR) ? ADDR_ZERO : (addr_q + ADDR_ONE);
    assign last_issue_s  = (remaining_q == REM_ONE);

    // A read may issue only if its word is guaranteed a FIFO slot when it returns.
    assign occ_s   = {1'b0, head_vld_q} + {1'b0, tail_vld_q} + {1'b0, inflight_q};
    assign limit_s = 2'd1 + {1'b0, pop_s};
    assign issue_s = (state_q == READ) && !abort && (occ_s <= limit_s);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort takes priority over the final handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok_s) state_d = READ;
                else            state_d = IDLE;
            end
            READ: begin
                if (abort)                         state_d = IDLE;
                else if (issue_s && last_issue_s)  state_d = DRAIN;
                else                               state_d = READ;
            end
            DRAIN: begin
                if (abort)                         state_d = IDLE;
                else if (pop_s && head_last_q)     state_d = IDLE;
                else                               state_d = DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address/count, output FIFO and status outputs.
    always_comb begin
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        head_vld_d      = head_vld_q;
        head_last_d     = head_last_q;
        head_data_d     = head_data_q;
        tail_vld_d      = tail_vld_q;
        tail_last_d     = tail_last_q;
        tail_data_d     = tail_data_q;
        done_d          = 1'b0;

        if (start_ok_s) begin
            addr_d      = start_addr;
            remaining_d = len_clamped_s;
        end else if (issue_s) begin
            remaining_d     = remaining_q - REM_ONE;
            // Hold the final address so ram_addr only ever shows issued addresses.
            addr_d          = last_issue_s ? addr_q : addr_next_s;
            inflight_d      = 1'b1;
            inflight_last_d = last_issue_s;
        end else begin
            addr_d      = addr_q;
            remaining_d = remaining_q;
        end

        case ({head_vld_q, tail_vld_q})
            2'b00: begin
                if (push_s) begin
                    head_vld_d  = 1'b1;
                    head_data_d = ram_dat_out;
                    head_last_d = inflight_last_q;
                end else begin
                    head_vld_d  = 1'b0;
                end
            end
            2'b10: begin
                if (push_s && pop_s) begin
                    head_data_d = ram_dat_out;
                    head_last_d = inflight_last_q;
                end else if (push_s) begin
                    tail_vld_d  = 1'b1;
                    tail_data_d = ram_dat_out;
                    tail_last_d = inflight_last_q;
                end else if (pop_s) begin
                    head_vld_d  = 1'b0;
                    head_last_d = 1'b0;
                end else begin
                    head_vld_d  = 1'b1;
                end
            end
            2'b11: begin
                if (pop_s) begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                    if (push_s) begin
                        tail_data_d = ram_dat_out;
                        tail_last_d = inflight_last_q;
                    end else begin
                        tail_vld_d  = 1'b0;
                        tail_last_d = 1'b0;
                    end
                end else begin
                    tail_vld_d = 1'b1;
                end
            end
            default: begin
                head_vld_d  = 1'b0;
                head_last_d = 1'b0;
                tail_vld_d  = 1'b0;
                tail_last_d = 1'b0;
            end
        endcase

        if (abort_ok_s) begin
            head_vld_d      = 1'b0;
            head_last_d     = 1'b0;
            tail_vld_d      = 1'b0;
            tail_last_d     = 1'b0;
            inflight_d      = 1'b0;
            inflight_last_d = 1'b0;
            done_d          = 1'b0;
        end else begin
            done_d = pop_s && head_last_q && (state_q != IDLE);
        end

        busy_d = (state_d != IDLE);
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q          <= ADDR_ZERO;
            remaining_q     <= LEN_ZERO;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            head_vld_q      <= 1'b0;
            head_last_q     <= 1'b0;
            head_data_q     <= {WIDTH{1'b0}};
            tail_vld_q      <= 1'b0;
            tail_last_q     <= 1'b0;
            tail_data_q     <= {WIDTH{1'b0}};
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            head_vld_q      <= head_vld_d;
            head_last_q     <= head_last_d;
            head_data_q     <= head_data_d;
            tail_vld_q      <= tail_vld_d;
            tail_last_q     <= tail_last_d;
            tail_data_q     <= tail_data_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign ram_addr       = addr_q;
    assign ram_we         = 1'b0;
    assign busy           = busy_q;
    assign done           = done_q;
    assign m_if.m_data    = head_data_q;
    assign m_if.m_valid   = head_vld_q;
    assign m_if.m_last    = head_last_q;

endmodule

// File: tb/tb_debug_ram_reader.sv
// Randomized bench for debug_ram_reader: a behavioural RAM plus a reference model that
// derives each expected stream as mem[(start+i) mod DEPTH] for min(length, DEPTH) words.
module tb_debug_ram_reader;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic [AW-1:0]    start_addr;
    logic [AW:0]      length;
    logic             abort;
    logic             busy;
    logic             done;
    logic [AW-1:0]    ram_addr;
    logic             ram_we;
    logic [WIDTH-1:0] ram_dat_out;
    logic [WIDTH-1:0] mem [DEPTH];

    debug_ram_reader_if #(.WIDTH(WIDTH)) s_if ();

    debug_ram_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .start(start), .start_addr(start_addr),
        .length(length), .abort(abort), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_dat_out(ram_dat_out), .m_if(s_if)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + 32'(i);
    end

    always @(posedge clk) ram_dat_out <= mem[ram_addr];

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] obs_data [$];
    bit               obs_last [$];
    int               addr_seq [$];
    int first_valid_c, gaps, stall_err, max_lead, done_cnt, done_delay;
    int busy_at1, busy_seen, abort_ok, timed_out;

    function automatic logic [WIDTH-1:0] exp_word(input int sa, input int i);
        return mem[(sa + i) % DEPTH];
    endfunction

    function automatic int exp_count(input int len);
        return (len > DEPTH) ? DEPTH : len;
    endfunction

    // Runs one readout and records what the stream did; the calling test judges it.
    task automatic do_read(input int sa, input int len, input int pct,
                           input int abort_after, input int poke_c);
        logic [WIDTH-1:0] prev_data;
        bit prev_last, prev_stall, aborted, hs;
        int c, idle_run, accepted, lead, n, abort_c, last_hs_c;
        obs_data.delete(); obs_last.delete(); addr_seq.delete();
        first_valid_c = -1; gaps = 0; stall_err = 0; max_lead = 0; done_cnt = 0;
        done_delay = -1; busy_at1 = 0; busy_seen = 0; abort_ok = 0; timed_out = 0;
        n = exp_count(len); accepted = 0; aborted = 0; prev_stall = 0; idle_run = 0;
        abort_c = -10; last_hs_c = -1; prev_data = '0; prev_last = 0;
        @(negedge clk);
        start = 1'b1; start_addr = AW'(sa); length = (AW+1)'(len); abort = 1'b0;
        s_if.m_ready = 1'b0;
        c = 0;
        while (1) begin
            @(negedge clk);
            c++;
            start = 1'b0; abort = 1'b0;
            if (c == poke_c) begin
                start = 1'b1; start_addr = AW'(sa + 5); length = 5'd3;
            end
            if (c == 1) busy_at1 = int'(busy);
            if (busy) busy_seen = 1;
            if (done) begin
                done_cnt++;
                if (last_hs_c >= 0) done_delay = c - last_hs_c;
            end
            if (aborted && c == abort_c + 1) abort_ok = int'(!s_if.m_valid && !busy);
            if (prev_stall && (!s_if.m_valid || s_if.m_data !== prev_data || s_if.m_last !== prev_last))
                stall_err++;
            if (s_if.m_valid && first_valid_c < 0) first_valid_c = c;
            if (!s_if.m_valid && first_valid_c >= 0 && accepted < n && !aborted) gaps++;
            if (c == 1 || (busy && int'(ram_addr) != addr_seq[$])) addr_seq.push_back(int'(ram_addr));
            if (busy && accepted >= 1 && accepted < n) begin
                lead = (int'(ram_addr) + DEPTH - ((sa + accepted - 1) % DEPTH)) % DEPTH;
                if (lead > max_lead) max_lead = lead;
            end
            s_if.m_ready = ($urandom_range(99) < pct);
            if (!aborted && abort_after > 0 && accepted == abort_after) begin
                abort = 1'b1; s_if.m_ready = 1'b0; aborted = 1; abort_c = c;
            end
            hs = s_if.m_valid && s_if.m_ready;
            prev_stall = s_if.m_valid && !s_if.m_ready && !aborted;
            prev_data = s_if.m_data; prev_last = s_if.m_last;
            if (hs) begin
                obs_data.push_back(s_if.m_data);
                obs_last.push_back(s_if.m_last);
                accepted++;
                if (s_if.m_last) last_hs_c = c;
            end
            if (!busy && !s_if.m_valid && c > 1) idle_run++;
            else idle_run = 0;
            if (idle_run >= 4) break;
            if (c >= 400) begin timed_out = 1; break; end
        end
        s_if.m_ready = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 7;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        if (s_if.m_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", s_if.m_valid); else n_pass++;
        if (s_if.m_last !== 1'b0) $display("FAIL reset_last: got %b want 0", s_if.m_last); else n_pass++;
        if (s_if.m_data !== 32'h0) $display("FAIL reset_data: got %h want 0", s_if.m_data); else n_pass++;
        if (ram_addr !== 4'd0) $display("FAIL reset_addr: got %0d want 0", ram_addr); else n_pass++;
        if (ram_we !== 1'b0) $display("FAIL reset_we: got %b want 0", ram_we); else n_pass++;
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_basic;
        do_read(3, 5, 100, 0, 0);
        n_checks += 7;
        if (timed_out != 0) $display("FAIL basic_timeout: got %0d want 0", timed_out); else n_pass++;
        if (obs_data.size() != 5) $display("FAIL basic_count: got %0d want 5", obs_data.size()); else n_pass++;
        if (first_valid_c != 3) $display("FAIL basic_latency: got %0d want 3", first_valid_c); else n_pass++;
        if (gaps != 0) $display("FAIL basic_gaps: got %0d want 0", gaps); else n_pass++;
        if (done_cnt != 1) $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); else n_pass++;
        if (done_delay != 1) $display("FAIL basic_done_delay: got %0d want 1", done_delay); else n_pass++;
        if (busy_at1 != 1) $display("FAIL basic_busy_rise: got %0d want 1", busy_at1); else n_pass++;
        for (int i = 0; i < obs_data.size(); i++) begin
            n_checks += 2;
            if (obs_data[i] !== exp_word(3, i))
                $display("FAIL basic_data[%0d]: got %h want %h", i, obs_data[i], exp_word(3, i));
            else n_pass++;
            if (obs_last[i] != (i == 4)) $display("FAIL basic_last[%0d]: got %0d want %0d", i, obs_last[i], i == 4);
            else n_pass++;
        end
    endtask

    task automatic test_wrap;
        do_read(14, 4, 100, 0, 0);
        n_checks += 3;
        if (timed_out != 0) $display("FAIL wrap_timeout: got %0d want 0", timed_out); else n_pass++;
        if (obs_data.size() != 4) $display("FAIL wrap_count: got %0d want 4", obs_data.size()); else n_pass++;
        if (addr_seq.size() != 4) $display("FAIL wrap_addr_count: got %0d want 4", addr_seq.size()); else n_pass++;
        for (int i = 0; i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_word(14, i))
                $display("FAIL wrap_data[%0d]: got %h want %h", i, obs_data[i], exp_word(14, i));
            else n_pass++;
        end
        for (int i = 0; i < addr_seq.size(); i++) begin
            n_checks++;
            if (addr_seq[i] != (14 + i) % DEPTH)
                $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, addr_seq[i], (14 + i) % DEPTH);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        int sa;
        for (int t = 0; t < 6; t++) begin
            sa = int'($urandom_range(DEPTH - 1));
            do_read(sa, 8, 50, 0, 0);
            n_checks += 5;
            if (timed_out != 0) $display("FAIL bp_timeout: got %0d want 0", timed_out); else n_pass++;
            if (obs_data.size() != 8) $display("FAIL bp_count: got %0d want 8", obs_data.size()); else n_pass++;
            if (stall_err != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_err); else n_pass++;
            if (max_lead > 3) $display("FAIL bp_lead: got %0d want <=3", max_lead); else n_pass++;
            if (done_cnt != 1) $display("FAIL bp_done: got %0d want 1", done_cnt); else n_pass++;
            for (int i = 0; i < obs_data.size(); i++) begin
                n_checks += 2;
                if (obs_data[i] !== exp_word(sa, i))
                    $display("FAIL bp_data[%0d]: got %h want %h", i, obs_data[i], exp_word(sa, i));
                else n_pass++;
                if (obs_last[i] != (i == 7)) $display("FAIL bp_last[%0d]: got %0d want %0d", i, obs_last[i], i == 7);
                else n_pass++;
            end
        end
    endtask

    task automatic test_edges;
        do_read(5, 0, 100, 0, 0);
        n_checks += 3;
        if (obs_data.size() != 0) $display("FAIL zero_beats: got %0d want 0", obs_data.size()); else n_pass++;
        if (done_cnt != 0) $display("FAIL zero_done: got %0d want 0", done_cnt); else n_pass++;
        if (busy_seen != 0) $display("FAIL zero_busy: got %0d want 0", busy_seen); else n_pass++;

        do_read(9, 20, 100, 0, 0);
        n_checks += 3;
        if (obs_data.size() != 16) $display("FAIL clamp_count: got %0d want 16", obs_data.size()); else n_pass++;
        if (done_cnt != 1) $display("FAIL clamp_done: got %0d want 1", done_cnt); else n_pass++;
        if (timed_out != 0) $display("FAIL clamp_timeout: got %0d want 0", timed_out); else n_pass++;
        for (int i = 0; i < obs_data.size(); i++) begin
            n_checks += 2;
            if (obs_data[i] !== exp_word(9, i))
                $display("FAIL clamp_data[%0d]: got %h want %h", i, obs_data[i], exp_word(9, i));
            else n_pass++;
            if (obs_last[i] != (i == 15)) $display("FAIL clamp_last[%0d]: got %0d want %0d", i, obs_last[i], i == 15);
            else n_pass++;
        end

        do_read(2, 8, 70, 0, 3);
        n_checks += 2;
        if (obs_data.size() != 8) $display("FAIL busy_start_count: got %0d want 8", obs_data.size()); else n_pass++;
        if (done_cnt != 1) $display("FAIL busy_start_done: got %0d want 1", done_cnt); else n_pass++;
        for (int i = 0; i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_word(2, i))
                $display("FAIL busy_start_data[%0d]: got %h want %h", i, obs_data[i], exp_word(2, i));
            else n_pass++;
        end
    endtask

    task automatic test_abort;
        do_read(4, 10, 100, 3, 0);
        n_checks += 4;
        if (abort_ok != 1) $display("FAIL abort_idle: got %0d want 1", abort_ok); else n_pass++;
        if (done_cnt != 0) $display("FAIL abort_done: got %0d want 0", done_cnt); else n_pass++;
        if (obs_data.size() != 3) $display("FAIL abort_count: got %0d want 3", obs_data.size()); else n_pass++;
        if (timed_out != 0) $display("FAIL abort_timeout: got %0d want 0", timed_out); else n_pass++;
        for (int i = 0; i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_word(4, i))
                $display("FAIL abort_data[%0d]: got %h want %h", i, obs_data[i], exp_word(4, i));
            else n_pass++;
        end
        do_read(0, 2, 100, 0, 0);
        n_checks += 2;
        if (obs_data.size() != 2) $display("FAIL post_abort_count: got %0d want 2", obs_data.size()); else n_pass++;
        if (done_cnt != 1) $display("FAIL post_abort_done: got %0d want 1", done_cnt); else n_pass++;
        for (int i = 0; i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_word(0, i))
                $display("FAIL post_abort_data[%0d]: got %h want %h", i, obs_data[i], exp_word(0, i));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1; start_addr = 4'd2; length = 5'd12; s_if.m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        n_checks += 6;
        if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else n_pass++;
        if (s_if.m_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", s_if.m_valid); else n_pass++;
        if (s_if.m_last !== 1'b0) $display("FAIL midrst_last: got %b want 0", s_if.m_last); else n_pass++;
        if (s_if.m_data !== 32'h0) $display("FAIL midrst_data: got %h want 0", s_if.m_data); else n_pass++;
        if (ram_addr !== 4'd0) $display("FAIL midrst_addr: got %0d want 0", ram_addr); else n_pass++;
        resetn = 1'b1; s_if.m_ready = 1'b0;
        do_read(7, 3, 100, 0, 0);
        n_checks += 2;
        if (obs_data.size() != 3) $display("FAIL midrst_after_count: got %0d want 3", obs_data.size()); else n_pass++;
        if (done_cnt != 1) $display("FAIL midrst_after_done: got %0d want 1", done_cnt); else n_pass++;
        for (int i = 0; i < obs_data.size(); i++) begin
            n_checks++;
            if (obs_data[i] !== exp_word(7, i))
                $display("FAIL midrst_after_data[%0d]: got %h want %h", i, obs_data[i], exp_word(7, i));
            else n_pass++;
        end
    endtask

    task automatic test_random;
        int sa, len, pct, n;
        for (int t = 0; t < 10; t++) begin
            sa  = int'($urandom_range(DEPTH - 1));
            len = int'($urandom_range(20));
            pct = int'($urandom_range(100, 30));
            n   = exp_count(len);
            do_read(sa, len, pct, 0, 0);
            n_checks += 4;
            if (obs_data.size() != n) $display("FAIL rand_count: got %0d want %0d", obs_data.size(), n); else n_pass++;
            if (done_cnt != (n > 0 ? 1 : 0)) $display("FAIL rand_done: got %0d want %0d", done_cnt, n > 0); else n_pass++;
            if (stall_err != 0) $display("FAIL rand_stable: got %0d want 0", stall_err); else n_pass++;
            if (timed_out != 0) $display("FAIL rand_timeout: got %0d want 0", timed_out); else n_pass++;
            for (int i = 0; i < obs_data.size(); i++) begin
                n_checks++;
                if (obs_data[i] !== exp_word(sa, i))
                    $display("FAIL rand_data[%0d]: got %h want %h", i, obs_data[i], exp_word(sa, i));
                else n_pass++;
            end
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        start_addr = 4'd0; length = 5'd0; s_if.m_ready = 1'b0;
        test_reset;
        test_basic;
        test_wrap;
        test_backpressure;
        test_edges;
        test_abort;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
